csr_timer: RTL and testbench
============================

# csr_timer

Core-local LoongArch-style CSR timer: holds TCFG (enable, periodic, initial value), a down-counting TVAL, the TI interrupt-status bit cleared through TICLR, and a free-running 64-bit stable counter. It sits directly upstream of the interrupt controller. Its registered `csr_timer_intr_sync` level is the controller's timer-interrupt request, and it stays high until software writes TICLR. CSR writes arrive from the CSR write port in the W stage; reads are combinational from the registers.

## Interface
Parameters:
- `TIMER_W`, default 32: TVAL/InitVal width; range 8..32.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high reset.
- `csr_tcfg_wen` in 1: write TCFG this cycle.
- `csr_ticlr_wen` in 1: write TICLR this cycle.
- `csr_wdata` in 32: CSR write data.
- `csr_tcfg_rdata` out 32: `{zero-pad, initval[TIMER_W-1:2], periodic, en}`.
- `csr_tval_rdata` out 32: TVAL, zero-extended.
- `stable_cnt` out 64: free-running counter for rdcnt.
- `csr_timer_intr_sync` out 1: TI level, registered; feeds the interrupt controller.
- `timer_expire_pulse` out 1: one-cycle, registered; high the cycle TI is set by an expiry.

## Operation
- Reset value of every register and output is 0. FSM state after reset is IDLE.
- TCFG write:
  - en ← `wdata[0]`, periodic ← `wdata[1]`, initval ← `wdata[TIMER_W-1:2]`.
  - TVAL ← `{wdata[TIMER_W-1:2], 2'b00}`.
  - State ← RUN if `wdata[0]` is 1, otherwise IDLE.
- FSM states:
  - IDLE: TVAL holds.
  - RUN: TVAL decrements by 1 per cycle.
  - STOP: one-shot finished; TVAL held at 0.
- Expiry event: state is RUN, TVAL is 0, and there is no TCFG write this cycle. On expiry:
  - TI ← 1 and `timer_expire_pulse` ← 1.
  - If periodic, TVAL ← `{initval, 2'b00}` and state stays RUN.
  - If not periodic, state ← STOP and TVAL stays 0.
- TVAL never wraps below 0; the RUN decrement applies only when TVAL is nonzero.
- TICLR write with `wdata[0]` = 1 clears TI. With `wdata[0]` = 0 it has no effect. TICLR never changes TVAL or the state.
- Priorities:
  - A TCFG write overrides counting and suppresses an expiry in the same cycle.
  - Expiry (set) beats a same-cycle TICLR clear, so no event is lost.
  - Simultaneous TCFG and TICLR writes both take effect.
- `stable_cnt` increments by 1 every cycle from reset and wraps at 2^64−1 → 0. It is not writable.
- When reset asserts mid-count, everything returns to 0 asynchronously. Counting restarts only after a new TCFG write.

## Timing
- A TCFG write at edge N makes the new values visible on `csr_tcfg_rdata`/`csr_tval_rdata` from N+1.
- Load value L, RUN:
  - TVAL reads L at N+1 and 0 at N+1+L.
  - Expiry occurs in cycle N+1+L; TI rises at edge N+2+L.
- Periodic period is L+1 cycles.
- L = 0 with en: TI rises at N+2.
- A TICLR at edge M drops TI from M+1, unless an expiry occurs in the same cycle.
- Interrupt-controller latency: its `vld_d` qualification adds its own cycles; `csr_timer_intr_sync` is a stable level from a flop (no glitches).

## Structure
- Shared header `csr_timer_defs.vh` holds:
  - State encodings `TMR_IDLE`=2'd0, `TMR_RUN`=2'd1, `TMR_STOP`=2'd2.
  - Bit positions `TCFG_EN_BIT`=0, `TCFG_PER_BIT`=1, `TICLR_CLR_BIT`=0.
  - CSR addresses TCFG=0x41, TVAL=0x42, TICLR=0x44 (used by CSR decode).
- One sub-module, `timer_down_cnt`: parameterised TIMER_W down-counter with load, decrement-enable and zero flag.
- The FSM, TI logic and stable counter live in the top module.

## Test plan
- Reset mid-count (TVAL=0x37): assert `reset` → TVAL, TI, state and `stable_cnt` are 0 immediately; no TI afterward without a TCFG write.
- One-shot: TCFG ← 0x0000_0021 (L=32) → TI rises exactly 34 cycles after the write edge with a 1-cycle `timer_expire_pulse`; TVAL then holds 0 in STOP; TI holds until TICLR ← 1, then drops the next cycle.
- Periodic: TCFG ← 0x0000_0013 (L=16) → expiry pulses every 17 cycles; TVAL sequence 16..0,16; clear TI between pulses and check it is re-set.
- Collisions:
  - TICLR in the expiry cycle → TI stays 1.
  - TCFG ← 0x0000_0009 in the expiry cycle → no pulse, TVAL=8, RUN.
- Disable: TCFG ← 0 while RUN → state IDLE, TVAL=0, no TI ever; TICLR with `wdata[0]`=0 leaves a set TI unchanged.
- `stable_cnt`: force it to 0xFFFF_FFFF_FFFF_FFFE in simulation → next values are …FFFF, then 0x0; it increments every cycle independent of timer state.

Source files
------------

// File: rtl/csr_timer_pkg.sv
// Shared definitions for the core-local CSR timer: FSM encodings,
// CSR bit positions and the CSR addresses used by the decoder.
package csr_timer_pkg;

    typedef logic [1:0] tmr_state_t;

    localparam tmr_state_t TMR_IDLE = 2'd0;
    localparam tmr_state_t TMR_RUN  = 2'd1;
    localparam tmr_state_t TMR_STOP = 2'd2;

    localparam int TCFG_EN_BIT   = 0;
    localparam int TCFG_PER_BIT  = 1;
    localparam int TICLR_CLR_BIT = 0;

    localparam logic [13:0] CSR_ADDR_TCFG  = 14'h41;
    localparam logic [13:0] CSR_ADDR_TVAL  = 14'h42;
    localparam logic [13:0] CSR_ADDR_TICLR = 14'h44;

endpackage

// File: rtl/timer_down_cnt.sv
// Loadable down-counter backing TVAL. It saturates at zero rather than
// wrapping, and a load always wins over a decrement in the same cycle.
module timer_down_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    input  logic         dec_i,
    output logic [W-1:0] val_o,
    output logic         zero_o
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    // Next count: load beats decrement, decrement stops at zero.
    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = loadVal_i;
        end else if (dec_i && (val_q != '0)) begin
            val_d = val_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o  = val_q;
    assign zero_o = (val_q == '0);

endmodule

// File: rtl/csr_timer.sv
// Core-local CSR timer: TCFG/TVAL/TICLR state, the TI interrupt level
// handed to the interrupt controller, and the 64-bit stable counter.
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_tcfg_wen,
    input  logic        csr_ticlr_wen,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_tcfg_rdata,
    output logic [31:0] csr_tval_rdata,
    output logic [63:0] stable_cnt,
    output logic        csr_timer_intr_sync,
    output logic        timer_expire_pulse
);

    logic                 en_q;
    logic                 en_d;
    logic                 periodic_q;
    logic                 periodic_d;
    logic [TIMER_W-3:0]   initVal_q;
    logic [TIMER_W-3:0]   initVal_d;
    tmr_state_t           state_q;
    tmr_state_t           state_d;
    logic                 ti_q;
    logic                 ti_d;
    logic                 pulse_q;
    logic [63:0]          stableCnt_q;

    logic [TIMER_W-1:0]   tval;
    logic                 tvalZero;
    logic                 expiry;
    logic                 cntLoad;
    logic [TIMER_W-1:0]   cntLoadVal;
    logic                 cntDec;
    logic                 tiClear;

    // An expiry needs a running timer at zero; a TCFG write the same
    // cycle reprograms the timer and swallows the event.
    always_comb begin
        expiry  = (state_q == TMR_RUN) && tvalZero && !csr_tcfg_wen;
        tiClear = csr_ticlr_wen && csr_wdata[TICLR_CLR_BIT];
    end

    // TVAL control: software loads from write data, periodic expiry
    // reloads from the stored initial value, otherwise count down in RUN.
    always_comb begin
        cntLoad    = csr_tcfg_wen || (expiry && periodic_q);
        cntLoadVal = {initVal_q, 2'b00};
        if (csr_tcfg_wen) begin
            cntLoadVal = {csr_wdata[TIMER_W-1:2], 2'b00};
        end
        cntDec = (state_q == TMR_RUN) && !csr_tcfg_wen;
    end

    timer_down_cnt #(
        .W (TIMER_W)
    ) u_down_cnt (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cntLoad),
        .loadVal_i (cntLoadVal),
        .dec_i     (cntDec),
        .val_o     (tval),
        .zero_o    (tvalZero)
    );

    // TCFG fields and FSM next state; a TCFG write always decides the state.
    always_comb begin
        en_d       = en_q;
        periodic_d = periodic_q;
        initVal_d  = initVal_q;
        state_d    = state_q;
        if (csr_tcfg_wen) begin
            en_d       = csr_wdata[TCFG_EN_BIT];
            periodic_d = csr_wdata[TCFG_PER_BIT];
            initVal_d  = csr_wdata[TIMER_W-1:2];
            state_d    = csr_wdata[TCFG_EN_BIT] ? TMR_RUN : TMR_IDLE;
        end else begin
            case (state_q)
                TMR_IDLE: state_d = TMR_IDLE;
                TMR_RUN:  state_d = (expiry && !periodic_q) ? TMR_STOP : TMR_RUN;
                TMR_STOP: state_d = TMR_STOP;
                default:  state_d = TMR_IDLE;
            endcase
        end
    end

    // TI: a set from expiry takes priority so a racing clear cannot lose it.
    always_comb begin
        ti_d = ti_q;
        if (expiry) begin
            ti_d = 1'b1;
        end else if (tiClear) begin
            ti_d = 1'b0;
        end
    end

    // Configuration, FSM, interrupt and stable-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q        <= 1'b0;
            periodic_q  <= 1'b0;
            initVal_q   <= '0;
            state_q     <= TMR_IDLE;
            ti_q        <= 1'b0;
            pulse_q     <= 1'b0;
            stableCnt_q <= 64'd0;
        end else begin
            en_q        <= en_d;
            periodic_q  <= periodic_d;
            initVal_q   <= initVal_d;
            state_q     <= state_d;
            ti_q        <= ti_d;
            pulse_q     <= expiry;
            stableCnt_q <= stableCnt_q + 64'd1;
        end
    end

    // Read views, zero-extended to the 32-bit CSR width.
    always_comb begin
        csr_tcfg_rdata                = '0;
        csr_tcfg_rdata[TIMER_W-1:0]   = {initVal_q, periodic_q, en_q};
        csr_tval_rdata                = '0;
        csr_tval_rdata[TIMER_W-1:0]   = tval;
    end

    assign stable_cnt          = stableCnt_q;
    assign csr_timer_intr_sync = ti_q;
    assign timer_expire_pulse  = pulse_q;

endmodule

// File: tb/tb_csr_timer.sv
// Directed scoreboard bench for csr_timer. Inputs change on the falling
// edge and outputs are sampled on the falling edge, so a write launched
// in the cycle after edge N is captured at edge N+1.
module tb_csr_timer;

    localparam int S_TVAL   = 0;
    localparam int S_TI     = 1;
    localparam int S_PULSE  = 2;
    localparam int S_TCFG   = 3;
    localparam int S_STABLE = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        csr_tcfg_wen;
    logic        csr_ticlr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_tcfg_rdata;
    logic [31:0] csr_tval_rdata;
    logic [63:0] stable_cnt;
    logic        csr_timer_intr_sync;
    logic        timer_expire_pulse;

    exp_t        expQ[$];
    int          errors;
    int          checks;
    logic [63:0] refCnt;
    int          cnt;
    int          pulses;

    csr_timer #(
        .TIMER_W (32)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .csr_tcfg_wen        (csr_tcfg_wen),
        .csr_ticlr_wen       (csr_ticlr_wen),
        .csr_wdata           (csr_wdata),
        .csr_tcfg_rdata      (csr_tcfg_rdata),
        .csr_tval_rdata      (csr_tval_rdata),
        .stable_cnt          (stable_cnt),
        .csr_timer_intr_sync (csr_timer_intr_sync),
        .timer_expire_pulse  (timer_expire_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference free-running count: +1 per rising edge out of reset.
    always @(posedge clk or posedge reset) begin
        if (reset) refCnt <= 64'd0;
        else       refCnt <= refCnt + 64'd1;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            S_TVAL:   return {32'd0, csr_tval_rdata};
            S_TI:     return {63'd0, csr_timer_intr_sync};
            S_PULSE:  return {63'd0, timer_expire_pulse};
            S_TCFG:   return {32'd0, csr_tcfg_rdata};
            S_STABLE: return stable_cnt;
            default:  return 64'hDEAD_DEAD_DEAD_DEAD;
        endcase
    endfunction

    task automatic pushExp(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [63:0] obs;
        while (expQ.size() != 0) begin
            e   = expQ.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic tcfgWen, input logic ticlrWen, input logic [31:0] wdata);
        csr_tcfg_wen  = tcfgWen;
        csr_ticlr_wen = ticlrWen;
        csr_wdata     = wdata;
        @(negedge clk);
        csr_tcfg_wen  = 1'b0;
        csr_ticlr_wen = 1'b0;
        csr_wdata     = 32'd0;
    endtask

    task automatic waitTi(output int n);
        n = 0;
        while (!csr_timer_intr_sync && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic waitPulse(output int n);
        n = 0;
        while (!timer_expire_pulse && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        csr_tcfg_wen  = 1'b0;
        csr_ticlr_wen = 1'b0;
        csr_wdata     = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        pushExp("rst_tval", S_TVAL, 64'd0);
        pushExp("rst_ti", S_TI, 64'd0);
        pushExp("rst_pulse", S_PULSE, 64'd0);
        pushExp("rst_tcfg", S_TCFG, 64'd0);
        pushExp("rst_stable", S_STABLE, 64'd0);
        checkOutput();
        reset = 1'b0;
        @(negedge clk);
        pushExp("stable_first", S_STABLE, 64'd1);
        checkOutput();

        // One-shot, L=32: TI at launch edge + 34
        applyStimulus(1'b1, 1'b0, 32'h0000_0021);
        pushExp("os_tcfg", S_TCFG, 64'h21);
        pushExp("os_tval_load", S_TVAL, 64'd32);
        pushExp("os_ti_low", S_TI, 64'd0);
        checkOutput();
        waitTi(cnt);
        checkValue("os_latency", cnt + 1, 34);
        pushExp("os_pulse", S_PULSE, 64'd1);
        pushExp("os_tval_zero", S_TVAL, 64'd0);
        checkOutput();
        @(negedge clk);
        pushExp("os_pulse_1cyc", S_PULSE, 64'd0);
        pushExp("os_ti_hold", S_TI, 64'd1);
        checkOutput();
        repeat (5) @(negedge clk);
        pushExp("os_stop_tval", S_TVAL, 64'd0);
        pushExp("os_stop_ti", S_TI, 64'd1);
        pushExp("os_no_repulse", S_PULSE, 64'd0);
        pushExp("os_stable", S_STABLE, refCnt);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 32'h1);
        pushExp("os_ticlr", S_TI, 64'd0);
        pushExp("os_ticlr_tval", S_TVAL, 64'd0);
        checkOutput();

        // Periodic, L=16: TVAL 16..0 then reload, period 17
        applyStimulus(1'b1, 1'b0, 32'h0000_0013);
        pushExp("per_tcfg", S_TCFG, 64'h13);
        pushExp("per_tval_load", S_TVAL, 64'd16);
        checkOutput();
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            pushExp("per_tval_seq", S_TVAL, (k <= 16) ? 64'(16 - k) : 64'd16);
            pushExp("per_pulse_seq", S_PULSE, (k == 17) ? 64'd1 : 64'd0);
            checkOutput();
        end
        pushExp("per_ti_set", S_TI, 64'd1);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 32'h1);
        pushExp("per_ti_clr", S_TI, 64'd0);
        checkOutput();
        waitPulse(cnt);
        checkValue("per_period", 18 + cnt - 17, 17);
        pushExp("per_ti_reset", S_TI, 64'd1);
        pushExp("per_tval_reload", S_TVAL, 64'd16);
        checkOutput();

        // TICLR in the expiry cycle: set wins
        repeat (16) @(negedge clk);
        pushExp("col_tval_zero", S_TVAL, 64'd0);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 32'h1);
        pushExp("col_ticlr_ti", S_TI, 64'd1);
        pushExp("col_ticlr_pulse", S_PULSE, 64'd1);
        checkOutput();
        @(negedge clk);
        pushExp("col_ticlr_ti_after", S_TI, 64'd1);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 32'h0);
        pushExp("ticlr_bit0_zero", S_TI, 64'd1);
        checkOutput();
        applyStimulus(1'b0, 1'b1, 32'h1);
        pushExp("ticlr_clr_ti", S_TI, 64'd0);
        pushExp("ticlr_keeps_tval", S_TVAL, 64'd13);
        checkOutput();

        // TCFG in the expiry cycle: no pulse, new load, still running
        repeat (13) @(negedge clk);
        pushExp("col_tcfg_pre", S_TVAL, 64'd0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 32'h0000_0009);
        pushExp("col_tcfg_pulse", S_PULSE, 64'd0);
        pushExp("col_tcfg_tval", S_TVAL, 64'd8);
        pushExp("col_tcfg_rd", S_TCFG, 64'h09);
        pushExp("col_tcfg_ti", S_TI, 64'd0);
        checkOutput();
        @(negedge clk);
        pushExp("col_tcfg_run", S_TVAL, 64'd7);
        checkOutput();

        // Disable while running
        applyStimulus(1'b1, 1'b0, 32'h0);
        pushExp("dis_tval", S_TVAL, 64'd0);
        pushExp("dis_tcfg", S_TCFG, 64'd0);
        checkOutput();
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (timer_expire_pulse || csr_timer_intr_sync) pulses++;
        end
        checkValue("dis_no_ti", pulses, 0);
        pushExp("dis_tval_hold", S_TVAL, 64'd0);
        pushExp("dis_stable", S_STABLE, refCnt);
        checkOutput();

        // L=0 one-shot, then TCFG and TICLR together
        applyStimulus(1'b1, 1'b0, 32'h0000_0001);
        pushExp("l0_ti_low", S_TI, 64'd0);
        pushExp("l0_tval", S_TVAL, 64'd0);
        checkOutput();
        @(negedge clk);
        pushExp("l0_ti", S_TI, 64'd1);
        pushExp("l0_pulse", S_PULSE, 64'd1);
        checkOutput();
        @(negedge clk);
        pushExp("l0_stop_pulse", S_PULSE, 64'd0);
        checkOutput();
        applyStimulus(1'b1, 1'b1, 32'h0000_0005);
        pushExp("both_ti", S_TI, 64'd0);
        pushExp("both_tval", S_TVAL, 64'd4);
        pushExp("both_tcfg", S_TCFG, 64'h05);
        checkOutput();
        waitTi(cnt);
        checkValue("both_latency", cnt, 5);

        // Reset mid-count at TVAL=0x37
        applyStimulus(1'b1, 1'b0, 32'h0000_0041);
        repeat (9) @(negedge clk);
        pushExp("mid_tval", S_TVAL, 64'h37);
        pushExp("mid_ti", S_TI, 64'd1);
        checkOutput();
        #3;
        reset = 1'b1;
        #1;
        pushExp("arst_tval", S_TVAL, 64'd0);
        pushExp("arst_ti", S_TI, 64'd0);
        pushExp("arst_tcfg", S_TCFG, 64'd0);
        pushExp("arst_stable", S_STABLE, 64'd0);
        checkOutput();
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        pushExp("post_rst_ti", S_TI, 64'd0);
        pushExp("post_rst_tval", S_TVAL, 64'd0);
        pushExp("post_rst_pulse", S_PULSE, 64'd0);
        pushExp("post_rst_stable", S_STABLE, 64'd60);
        checkOutput();

        // Stable counter wrap
        force dut.stableCnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.stableCnt_q;
        pushExp("wrap_seed", S_STABLE, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput();
        @(negedge clk);
        pushExp("wrap_max", S_STABLE, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput();
        @(negedge clk);
        pushExp("wrap_zero", S_STABLE, 64'd0);
        checkOutput();
        @(negedge clk);
        pushExp("wrap_one", S_STABLE, 64'd1);
        checkOutput();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
